// File: rtl/scroll_ctrl_if.sv
// Signal bundle between the scroll controller and its buttons, switches, datapath and converter.
// There is no valid/ready handshake here: inputs are levels sampled every clk, step_pulse is a one-cycle strobe.
interface scroll_ctrl_if;
  logic        start;
  logic        stop;
  logic        step;
  logic        dir;
  logic [15:0] display_in;
  logic [3:0]  pos;
  logic        step_pulse;
  logic        running;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic [1:0]  fsm_state;

  modport master (
    output start, stop, step, dir, display_in,
    input  pos, step_pulse, running, an, digit, fsm_state
  );

  modport slave (
    input  start, stop, step, dir, display_in,
    output pos, step_pulse, running, an, digit, fsm_state
  );
endinterface

// File: rtl/scroll_ctrl.sv
// Scroll position controller with run/pause/single-step control and a 4-digit
// common-anode seven-segment scan multiplexer.
module scroll_ctrl #(
  parameter int STEP_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int DIV_W    = 27
) (
  input  logic         clk,
  input  logic         rst,
  scroll_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] SCAN_LAST = DIV_W'(SCAN_DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] step_cnt;
  logic [DIV_W-1:0] scan_cnt;
  logic [1:0]       scan_idx;
  logic [3:0]       pos_q;
  logic             pulse_q;
  logic             running_q;
  logic [3:0]       an_q;
  logic [3:0]       digit_q;
  logic             start_q, stop_q, step_q;

  logic             start_rise, stop_ev, start_ev, step_ev;
  logic [3:0]       next_pos;

  // Rising edges resolved by priority: stop beats start beats step.
  always_comb begin
    stop_ev    = bus.stop & ~stop_q;
    start_rise = bus.start & ~start_q;
    start_ev   = start_rise & ~stop_ev;
    step_ev    = bus.step & ~step_q & ~stop_ev & ~start_rise;
    next_pos   = bus.dir ? (pos_q - 4'd1) : (pos_q + 4'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      step_cnt  <= '0;
      pos_q     <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
      step_q  <= bus.step;
      pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          step_cnt <= '0;
          if (start_ev) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else if (step_ev) begin
            pos_q   <= next_pos;
            pulse_q <= 1'b1;
          end
        end
        RUN: begin
          // A stop freezes the prescaler and swallows a coincident terminal count.
          if (stop_ev) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            pos_q    <= next_pos;
            pulse_q  <= 1'b1;
          end else begin
            step_cnt <= step_cnt + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (stop_ev) begin
            state    <= IDLE;
            pos_q    <= '0;
            step_cnt <= '0;
          end else if (start_ev) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else if (step_ev) begin
            pos_q   <= next_pos;
            pulse_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Display scan runs regardless of the scroll state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an_q     <= 4'b1111;
      digit_q  <= '0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + DIV_W'(1);
      end
      case (scan_idx)
        2'd0: begin an_q <= 4'b0111; digit_q <= bus.display_in[15:12]; end
        2'd1: begin an_q <= 4'b1011; digit_q <= bus.display_in[11:8];  end
        2'd2: begin an_q <= 4'b1101; digit_q <= bus.display_in[7:4];   end
        2'd3: begin an_q <= 4'b1110; digit_q <= bus.display_in[3:0];   end
      endcase
    end
  end

  assign bus.pos        = pos_q;
  assign bus.step_pulse = pulse_q;
  assign bus.running    = running_q;
  assign bus.an         = an_q;
  assign bus.digit      = digit_q;
  assign bus.fsm_state  = state;

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
Controller for the 4-digit scrolling display datapath. Generates the scroll position and step strobe that drive the scroll datapath, with run/pause/single-step/direction control from debounced buttons. Time-multiplexes the 16-bit converted display word onto a common-anode 4-digit seven-segment scan (anode select plus selected nibble to the segment converter). Sits between board buttons/switches and the scroll datapath/converter.

Parameters:
STEP_DIV, 100_000_000, clk cycles per scroll step in RUN (≥2).
SCAN_DIV, 100_000, clk cycles each digit is lit during scan (≥2).
DIV_W, 27, width of both prescaler counters (must hold STEP_DIV-1 and SCAN_DIV-1).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  debounced button, synchronous to clk, level
stop  input  1  debounced button, synchronous to clk, level
step  input  1  debounced button, synchronous to clk, level
dir  input  1  switch: 0 = position increments, 1 = decrements
display_in  input  16  datapath word, digit0 = [15:12] ... digit3 = [3:0]
pos  output  4  scroll position fed to datapath base value
step_pulse  output  1  one-cycle strobe, high in the cycle pos changes
running  output  1  high while in RUN
an  output  4  anode enables, active-low, an[3] = digit0
digit  output  4  nibble for the currently lit digit, to converter

Behaviour:
- Clock/reset: one clock, clk; rst asynchronous, active-low. While rst=0: state=IDLE, pos=0, step_pulse=0, running=0, an=4'b1111, digit=0, both prescalers=0, scan_idx=0, edge-detect history=0. Reset mid-operation aborts any step; no pulse is emitted.
- Button handling: start/stop/step are rising-edge detected internally (one registered history bit each). A held button acts once. Edge events are valid the cycle after the input rises.
- Event priority in one cycle: stop > start > step. Lower-priority events in the same cycle are discarded.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: step prescaler held at 0; pos held. start → RUN. step → single step, stay IDLE. stop → no effect.
  - RUN: running=1. Step prescaler counts 0..STEP_DIV-1. At terminal count it wraps to 0 and a step occurs. stop → PAUSE; prescaler value frozen; a terminal count in the same cycle as stop is suppressed. start/step are ignored.
  - PAUSE: prescaler frozen; pos held. start → RUN, prescaler resumes from its frozen value. step → single step, stay PAUSE. stop → IDLE, pos cleared to 0, prescaler cleared.
- Step action: pos <= pos+1 (dir=0) or pos-1 (dir=1), modulo 16 (15+1 = 0, 0-1 = 15). step_pulse=1 in the same cycle the new pos appears, otherwise 0. dir is sampled in the step cycle. Latency from terminal count (or step edge detect) to new pos is 1 cycle.
- Scan: free-running in all states. scan prescaler counts 0..SCAN_DIV-1; at terminal count scan_idx advances 0→1→2→3→0.
- Scan outputs: an and digit are registered each cycle from scan_idx and display_in.
  - idx0: an=0111, digit=display_in[15:12]
  - idx1: an=1011, digit=[11:8]
  - idx2: an=1101, digit=[7:4]
  - idx3: an=1110, digit=[3:0]
  - Exactly one anode is low at all times after the first post-reset edge. A display_in change appears on digit 1 cycle later if that digit is lit.

Test Plan:
- STEP_DIV=4, SCAN_DIV=2. Reset low, then release → an=1111, pos=0 during reset; first edge gives an=0111, digit=display_in[15:12]. Scan order 0111,1011,1101,1110 with each held 2 cycles, repeating.
- Pulse start, dir=0 → running=1. step_pulse every 4 cycles; pos goes 1,2,...,15,0. Wrap 15→0 is checked.
- In RUN, pulse stop at prescaler=2 → PAUSE, pos frozen, no pulse. Pulse start → first pulse arrives 2 cycles later (prescaler resumed from 2).
- In PAUSE, set dir=1, pos=0, pulse step → pos=15 with one step_pulse. Hold step high for 10 cycles → exactly one step. Then pulse stop → IDLE, pos=0.
- start and stop rise in the same cycle from PAUSE → state goes to IDLE (stop wins). Stop coincident with a RUN terminal count → no step_pulse, pos unchanged.
- Assert rst=0 asynchronously mid-RUN, between clock edges → all outputs return to reset values immediately. After release, state is IDLE and no step occurs without start.
